lfsr_gen: RTL and testbench
===========================

LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 16, LFSR register width (>=4).
REQ-002 Parameter TAPS, default 16'h002D, feedback tap mask; bit i set means state[i] is XORed into the feedback bit.
REQ-003 Parameter SEED, default 16'hECEB, reset and substitute state; SHALL be non-zero.
REQ-004 Parameter OUT_W, default 8, bits produced per request (1..WIDTH).
REQ-005 Port clk, input, 1, sole clock; all state changes on posedge.
REQ-006 Port rst, input, 1, asynchronous active-high reset.
REQ-007 Port load, input, 1, seed-load strobe.
REQ-008 Port load_val, input, WIDTH, value to load.
REQ-009 Port req, input, 1, request for OUT_W random bits.
REQ-010 Port req_ready, output, 1, request accepted when req && req_ready at posedge.
REQ-011 Port out_valid, output, 1, out_bits valid.
REQ-012 Port out_ready, input, 1, consumer accepts out_bits when out_valid && out_ready.
REQ-013 Port out_bits, output, OUT_W, collected bits, first bit in LSB.
REQ-014 Port shift_reg, output, WIDTH, current LFSR state.
REQ-015 Port load_err, output, 1, one-cycle pulse on zero-value load.
REQ-016 Port period_done, output, 1, one-cycle pulse when state returns to start value.

Function
REQ-017 Step: fb = XOR of state[i] for all TAPS bits; emitted bit = state[0]; next state = (state >> 1) with fb in bit WIDTH-1.
REQ-018 FSM states IDLE, RUN, HOLD; req_ready = (state==IDLE) && !load.
REQ-019 IDLE, load=1: register <= load_val (or SEED if load_val==0); start value <= same; step count cleared; stays IDLE.
REQ-020 load_val==0 load: load_err high the following cycle only; otherwise load_err low.
REQ-021 load in RUN or HOLD: ignored, no load_err.
REQ-022 IDLE, req && req_ready: -> RUN, bit index cleared.
REQ-023 RUN: exactly one step per cycle; emitted bit written to out_bits[index]; after OUT_W steps -> HOLD.
REQ-024 HOLD: out_valid=1, out_bits and shift_reg stable; out_valid && out_ready -> IDLE, out_valid low next cycle.
REQ-025 Latency: req accepted at edge T, out_valid high after edge T+OUT_W; OUT_W=1 gives out_valid one cycle after acceptance.
REQ-026 No step occurs in IDLE or HOLD.
REQ-027 period_done pulses in the cycle after any step whose result equals start value, including mid-RUN.
REQ-028 out_bits bits not yet written in RUN hold their previous value; out_bits meaningful only with out_valid.

Reset
REQ-029 rst asynchronously forces state IDLE, shift_reg=SEED, start value=SEED, out_bits=0, out_valid=0, load_err=0, period_done=0; req_ready=1 once rst is low.
REQ-030 rst during RUN or HOLD discards the partial or pending output; nothing is delivered.

Structure
REQ-031 Package lfsr_pkg holds FSM state enum and default constants (16'h002D, 16'hECEB).
REQ-032 Sub-module lfsr_core (WIDTH, TAPS, SEED) holds the register with step and load inputs, outputs state and emitted bit; lfsr_gen holds the FSM, collection and period logic.

Verification
REQ-033 Default WIDTH/TAPS/SEED, OUT_W=4; reset, one request -> out_bits=4'hB, shift_reg=16'hBECE, out_valid 4 cycles after acceptance.
REQ-034 OUT_W=1; 65535 requests with random 0-3 cycle gaps between them -> each bit matches model; period_done exactly once, on last; shift_reg=16'hECEB.
REQ-035 load with load_val=0 in IDLE -> shift_reg=16'hECEB, one load_err pulse; load_val=16'h0001 -> shift_reg=16'h0001, no load_err.
REQ-036 out_ready held low 10 cycles in HOLD -> out_valid and out_bits stable, shift_reg unchanged; load during HOLD ignored.
REQ-037 rst asserted mid-RUN, asynchronously between edges -> outputs clear immediately; next request from 16'hECEB repeats REQ-033 result.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants and FSM encoding for the LFSR random-bit generator.
package lfsr_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam logic [15:0] DEF_TAPS  = 16'h002D;
    localparam logic [15:0] DEF_SEED  = 16'hECEB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register: shifts right, feedback XOR of tapped bits enters the MSB.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] state_o,
    output logic [WIDTH-1:0] next_o,
    output logic             bit_o
);

    logic [WIDTH-1:0] state_q, state_d;

    // next_o is exposed so the parent can spot a return to the start value
    assign next_o = {^(state_q & TAPS), state_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        if (load_i)
            state_d = load_val_i;
        else if (step_i)
            state_d = next_o;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= SEED;
        else
            state_q <= state_d;
    end

    assign state_o = state_q;
    assign bit_o   = state_q[0];

endmodule

// File: rtl/lfsr_gen.sv
// Request/response wrapper: collects OUT_W LFSR bits per request and holds them
// until the consumer takes them; also flags zero loads and full-period wrap.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED),
    parameter int unsigned      OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             req,
    output logic             req_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_bits,
    output logic [WIDTH-1:0] shift_reg,
    output logic             load_err,
    output logic             period_done
);

    localparam int unsigned IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    state_e           st_q, st_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [OUT_W-1:0] bits_q, bits_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic             err_q, err_d;
    logic             pdone_q, pdone_d;

    logic             load_en, step, core_bit;
    logic [WIDTH-1:0] load_eff, core_state, core_next;

    // A zero load would lock the LFSR, so it falls back to SEED
    assign load_en  = (st_q == ST_IDLE) && load;
    assign load_eff = (load_val == '0) ? SEED : load_val;
    assign step     = (st_q == ST_RUN);

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .step_i     (step),
        .load_i     (load_en),
        .load_val_i (load_eff),
        .state_o    (core_state),
        .next_o     (core_next),
        .bit_o      (core_bit)
    );

    always_comb begin
        st_d    = st_q;
        idx_d   = idx_q;
        bits_d  = bits_q;
        start_d = start_q;
        err_d   = load_en && (load_val == '0);
        pdone_d = step && (core_next == start_q);
        case (st_q)
            ST_IDLE: begin
                if (load)
                    start_d = load_eff;
                else if (req) begin
                    st_d  = ST_RUN;
                    idx_d = '0;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < OUT_W; i++)
                    if (idx_q == IDX_W'(i))
                        bits_d[i] = core_bit;
                if (idx_q == IDX_W'(OUT_W - 1))
                    st_d = ST_HOLD;
                else
                    idx_d = idx_q + 1'b1;
            end
            ST_HOLD: begin
                if (out_ready)
                    st_d = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            idx_q   <= '0;
            bits_q  <= '0;
            start_q <= SEED;
            err_q   <= 1'b0;
            pdone_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            idx_q   <= idx_d;
            bits_q  <= bits_d;
            start_q <= start_d;
            err_q   <= err_d;
            pdone_q <= pdone_d;
        end
    end

    assign req_ready   = (st_q == ST_IDLE) && !load;
    assign out_valid   = (st_q == ST_HOLD);
    assign out_bits    = bits_q;
    assign shift_reg   = core_state;
    assign load_err    = err_q;
    assign period_done = pdone_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench: stimulus pushes expected results, per-DUT monitors pop them
// on each output handshake. u4 uses default LFSR with OUT_W=4; u1 is a 4-bit
// maximal LFSR (x^4+x+1, period 15) with OUT_W=1 for full-period checks.
module tb_lfsr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        ld4, rq4, ordy4;
    logic [15:0] lv4;
    logic        rr4, ov4, le4, pd4;
    logic [3:0]  ob4;
    logic [15:0] sr4;

    logic        ld1, rq1, ordy1;
    logic [3:0]  lv1;
    logic        rr1, ov1, le1, pd1;
    logic [0:0]  ob1;
    logic [3:0]  sr1;

    lfsr_gen #(.OUT_W(4)) u4 (
        .clk(clk), .rst(rst), .load(ld4), .load_val(lv4), .req(rq4),
        .req_ready(rr4), .out_valid(ov4), .out_ready(ordy4), .out_bits(ob4),
        .shift_reg(sr4), .load_err(le4), .period_done(pd4)
    );

    lfsr_gen #(.WIDTH(4), .TAPS(4'h3), .SEED(4'h1), .OUT_W(1)) u1 (
        .clk(clk), .rst(rst), .load(ld1), .load_val(lv1), .req(rq1),
        .req_ready(rr1), .out_valid(ov1), .out_ready(ordy1), .out_bits(ob1),
        .shift_reg(sr1), .load_err(le1), .period_done(pd1)
    );

    typedef struct {
        logic [3:0]  bits;
        logic [15:0] sr;
    } exp4_t;

    exp4_t q4[$];
    logic  q1[$];
    int    pass_cnt = 0;
    int    tot_cnt  = 0;
    int    n_del1   = 0;
    int    pd1_cnt  = 0;
    int    pd4_cnt  = 0;

    // bit n = n-th output of x^4+x+1 LFSR seeded with 4'h1
    logic [14:0] seq4 = 15'h7591;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(negedge clk) begin : mon4
        exp4_t e;
        if (pd4) pd4_cnt++;
        if (ov4 && ordy4) begin
            if (q4.size() == 0)
                chk("u4_unexpected_output", 1, 0);
            else begin
                e = q4.pop_front();
                chk("u4_out_bits", ob4, e.bits);
                chk("u4_shift_reg", sr4, e.sr);
            end
        end
    end

    always @(negedge clk) begin : mon1
        logic eb;
        if (pd1) pd1_cnt++;
        if (ov1 && ordy1) begin
            if (q1.size() == 0)
                chk("u1_unexpected_output", 1, 0);
            else begin
                eb = q1.pop_front();
                chk("u1_out_bit", ob1, eb);
                chk("u1_period_done", pd1, (n_del1 % 15) == 14);
                n_del1++;
            end
        end
    end

    task automatic wait_rr4();
        int n = 0;
        while (!rr4 && n < 50) begin @(negedge clk); n++; end
        if (!rr4) chk("u4_req_ready_timeout", 0, 1);
    endtask

    task automatic issue4(input logic [3:0] eb, input logic [15:0] es);
        int n;
        wait_rr4();
        q4.push_back('{bits: eb, sr: es});
        rq4 = 1'b1;
        @(posedge clk); #1 rq4 = 1'b0;
        n = 0;
        while (!ov4 && n < 20) begin @(posedge clk); #1; n++; end
        chk("u4_latency", n, 4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, bad;
        rst = 1'b1; ld4 = 0; rq4 = 0; ordy4 = 1; lv4 = '0;
        ld1 = 0; rq1 = 0; ordy1 = 1; lv1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_shift_reg4", sr4, 16'hECEB);
        chk("rst_out_valid4", ov4, 0);
        chk("rst_out_bits4", ob4, 0);
        chk("rst_load_err4", le4, 0);
        chk("rst_period_done4", pd4, 0);
        chk("rst_shift_reg1", sr1, 4'h1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready4", rr4, 1);
        chk("rst_req_ready1", rr1, 1);

        issue4(4'hB, 16'hBECE);

        // reset in the middle of a run: partial result must vanish
        wait_rr4();
        rq4 = 1'b1;
        @(posedge clk); #1 rq4 = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("midrun_rst_out_bits", ob4, 0);
        chk("midrun_rst_shift_reg", sr4, 16'hECEB);
        chk("midrun_rst_out_valid", ov4, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("midrun_rst_req_ready", rr4, 1);
        issue4(4'hB, 16'hBECE);
        issue4(4'hE, 16'h2BEC);

        // zero load falls back to SEED with a one-cycle error pulse
        wait_rr4();
        ld4 = 1'b1; lv4 = 16'h0000;
        #1 chk("req_ready_during_load", rr4, 0);
        @(negedge clk); ld4 = 1'b0;
        chk("zero_load_shift_reg", sr4, 16'hECEB);
        chk("zero_load_err", le4, 1);
        @(negedge clk);
        chk("zero_load_err_one_cycle", le4, 0);
        ld4 = 1'b1; lv4 = 16'h0001;
        @(negedge clk); ld4 = 1'b0;
        chk("load_one_shift_reg", sr4, 16'h0001);
        chk("load_one_no_err", le4, 0);

        // consumer stalls for 10 cycles while a load is attempted
        ordy4 = 1'b0;
        issue4(4'h1, 16'h1000);
        ld4 = 1'b1; lv4 = 16'h1234;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!ov4 || ob4 !== 4'h1 || sr4 !== 16'h1000 || le4 || rr4) bad++;
        end
        chk("hold_stable_cycles_bad", bad, 0);
        @(posedge clk); #1 ld4 = 1'b0; ordy4 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("hold_valid_drop", ov4, 0);
        chk("hold_load_ignored_err", le4, 0);

        // three full periods on the 4-bit LFSR with random request gaps
        for (int i = 0; i < 45; i++) begin
            n = 0;
            while (!rr1 && n < 20) begin @(negedge clk); n++; end
            if (!rr1) chk("u1_req_ready_timeout", 0, 1);
            q1.push_back(seq4[i % 15]);
            rq1 = 1'b1;
            @(negedge clk); rq1 = 1'b0;
            if (i == 0) begin
                chk("u1_valid_at_accept", ov1, 0);
                @(negedge clk);
                chk("u1_valid_one_after", ov1, 1);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        n = 0;
        while ((q1.size() != 0 || q4.size() != 0) && n < 50) begin @(negedge clk); n++; end
        chk("queue1_drained", q1.size(), 0);
        chk("queue4_drained", q4.size(), 0);
        @(negedge clk);
        chk("u1_shift_reg_after_periods", sr1, 4'h1);
        chk("u1_period_done_count", pd1_cnt, 3);
        chk("u4_period_done_count", pd4_cnt, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
